// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a single-ported data memory: round-robin on conflict, lockable bursts.
// Grant is combinational; read data returns one cycle after grant. An ungranted requester holds or drops.
module dmem_arbiter #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 1024,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             p0_req,
    input  logic             p0_we,
    input  logic             p0_lock,
    input  logic [AW-1:0]    p0_addr,
    input  logic [WIDTH-1:0] p0_wdata,
    output logic             p0_gnt,
    output logic             p0_rvalid,
    output logic [WIDTH-1:0] p0_rdata,
    input  logic             p1_req,
    input  logic             p1_we,
    input  logic             p1_lock,
    input  logic [AW-1:0]    p1_addr,
    input  logic [WIDTH-1:0] p1_wdata,
    output logic             p1_gnt,
    output logic             p1_rvalid,
    output logic [WIDTH-1:0] p1_rdata,
    output logic             mem_write,
    output logic [AW-1:0]    mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOCK0 = 2'd1;
    localparam logic [1:0] LOCK1 = 2'd2;

    logic [1:0]       state_q, state_d;
    logic             last_q, last_d;
    logic             p0_rvalid_q, p1_rvalid_q;
    logic [WIDTH-1:0] p0_rdata_q, p1_rdata_q;

    // last_q names the port granted most recently; on conflict the other port wins.
    always_comb begin
        p0_gnt = 1'b0;
        p1_gnt = 1'b0;
        if (reset_n) begin
            case (state_q)
                LOCK0:   p0_gnt = p0_req;
                LOCK1:   p1_gnt = p1_req;
                default: begin
                    if (p0_req && p1_req) begin
                        p0_gnt = last_q;
                        p1_gnt = !last_q;
                    end else begin
                        p0_gnt = p0_req;
                        p1_gnt = p1_req;
                    end
                end
            endcase
        end
    end

    always_comb begin
        state_d = IDLE;
        if (p0_gnt && p0_lock) begin
            state_d = LOCK0;
        end else if (p1_gnt && p1_lock) begin
            state_d = LOCK1;
        end
        last_d = last_q;
        if (p0_gnt) begin
            last_d = 1'b0;
        end else if (p1_gnt) begin
            last_d = 1'b1;
        end
    end

    always_comb begin
        mem_write = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (p0_gnt) begin
            mem_write = p0_we;
            mem_addr  = p0_addr;
            mem_wdata = p0_wdata;
        end else if (p1_gnt) begin
            mem_write = p1_we;
            mem_addr  = p1_addr;
            mem_wdata = p1_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            last_q      <= 1'b1;
            p0_rvalid_q <= 1'b0;
            p1_rvalid_q <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            p0_rvalid_q <= p0_gnt && !p0_we;
            p1_rvalid_q <= p1_gnt && !p1_we;
            if (p0_gnt && !p0_we) begin
                p0_rdata_q <= mem_rdata;
            end
            if (p1_gnt && !p1_we) begin
                p1_rdata_q <= mem_rdata;
            end
        end
    end

    assign p0_rvalid = p0_rvalid_q;
    assign p1_rvalid = p1_rvalid_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits.
REQ-002 Parameter DEPTH, default 1024, memory depth in words; AW = $clog2(DEPTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset_n  input  1  reset, synchronous, active-low.
REQ-005 p0_req / p1_req  input  1  requester n wants one memory access this cycle.
REQ-006 p0_we / p1_we  input  1  access is a write (1) or read (0).
REQ-007 p0_lock / p1_lock  input  1  hold ownership after this access (burst).
REQ-008 p0_addr / p1_addr  input  AW  word address.
REQ-009 p0_wdata / p1_wdata  input  WIDTH  write data.
REQ-010 p0_gnt / p1_gnt  output  1  access accepted this cycle (combinational).
REQ-011 p0_rvalid / p1_rvalid  output  1  registered read data valid.
REQ-012 p0_rdata / p1_rdata  output  WIDTH  registered read data.
REQ-013 mem_write  output  1  write strobe to data memory.
REQ-014 mem_addr  output  AW  address to data memory.
REQ-015 mem_wdata  output  WIDTH  write data to data memory.
REQ-016 mem_rdata  input  WIDTH  combinational read data from data memory for mem_addr.

Function
REQ-017 At most one grant per cycle; pN_gnt=1 means the access completes at the next rising edge.
REQ-018 mem_addr/mem_wdata SHALL mux the granted port; mem_write = gnt && granted port's we.
REQ-019 No grant: mem_write=0, mem_addr=0, mem_wdata=0.
REQ-020 States: IDLE, LOCK0, LOCK1; register last (1 bit, last port granted).
REQ-021 IDLE, single requester: that port is granted.
REQ-022 IDLE, both requesting: grant port != last (round-robin); last updates to the granted port on every grant.
REQ-023 IDLE -> LOCKn when port n is granted with pN_lock=1.
REQ-024 LOCKn: only port n may be granted (when pN_req=1); other port gnt=0 regardless of req.
REQ-025 LOCKn -> IDLE when pN_req=1 and pN_lock=0 (that beat is granted, final beat) or when pN_req=0 (no grant that cycle).
REQ-026 Granted read: pN_rdata <= mem_rdata and pN_rvalid <= 1 at the same edge; latency one cycle from gnt.
REQ-027 pN_rvalid SHALL be a one-cycle pulse per granted read; pN_rdata holds its last value otherwise.
REQ-028 Granted write: no rvalid pulse; write and read to the same address in consecutive cycles return the new data.
REQ-029 Requester holds req/we/addr/wdata/lock stable until gnt; deasserting req without gnt is legal and drops the request.

Reset
REQ-030 reset_n=0 sampled at an edge: state=IDLE, last=1, p0/p1_rvalid=0, p0/p1_rdata=0.
REQ-031 While reset_n=0: p0_gnt=p1_gnt=0 and mem_write=0, regardless of requests.
REQ-032 Reset mid-burst (LOCKn) SHALL abandon the lock; first post-reset conflict grants port 0.

Verification
REQ-033 Reset, then p0 write addr 10 data DEADBEEF alone -> p0_gnt=1, mem_write=1, mem_addr=10; next cycle p0 read addr 10 -> p0_rvalid pulse one cycle later, p0_rdata=DEADBEEF.
REQ-034 Both request reads every cycle for 4 cycles after reset -> grants alternate p0,p1,p0,p1; each rvalid one cycle after its gnt.
REQ-035 p1 granted with lock=1 for 3 beats (addr 20,21,22 writes CAFEBABE+i) while p0 requests -> p0_gnt=0 for all 3; 3rd beat lock=0 -> next cycle p0 granted.
REQ-036 In LOCK1, p1 drops req -> no grant that cycle, state IDLE; p0 granted the following cycle.
REQ-037 Assert reset_n=0 for one cycle during LOCK0 with both requesting -> gnts 0 during reset; after release p0 granted first, rvalids 0.
REQ-038 No requests -> mem_write=0, mem_addr=0, both rvalid=0 every cycle.
